// File: rtl/mem_hex_dumper_pkg.sv
// Shared types and constants for the memory hex dumper.
// Holds the FSM state encoding, the default bus widths and the ASCII codes used for text output.
// No ports; imported by the interface, the top and the nibble converter.
package mem_hex_dumper_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_REG_WIDTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HI      = 3'd3,
        ST_LO      = 3'd4,
        ST_SEP     = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_NL      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_A_LOWER = 8'h61;

endpackage

// File: rtl/mem_hex_dumper_if.sv
// Bus bundle between the hex dumper and its environment.
// Carries the dump request (start, start_addr, end_addr, busy, done), the memory read port
// (mem_re, mem_addr, mem_dout) and the character stream (char_valid, char_data, char_ready).
interface mem_hex_dumper_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic                  busy;
    logic                  done;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  char_valid;
    logic [7:0]            char_data;
    logic                  char_ready;

    // Environment side: requests dumps, serves memory reads, sinks characters.
    modport master (
        output start, start_addr, end_addr, mem_dout, char_ready,
        input  busy, done, mem_re, mem_addr, char_valid, char_data
    );

    // Dumper side.
    modport slave (
        input  start, start_addr, end_addr, mem_dout, char_ready,
        output busy, done, mem_re, mem_addr, char_valid, char_data
    );
endinterface

// File: rtl/mem_hex_dumper_nibble.sv
// Converts one 4-bit nibble to its lowercase ASCII hex digit, purely combinational.
// Ports: nibble_i (4-bit value), ascii_o (8-bit character '0'-'9' or 'a'-'f').
// Zero latency, no flow control.
module nibble_to_ascii
    import mem_hex_dumper_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_ZERO + {4'd0, nibble_i};
        end else begin
            ascii_o = ASCII_A_LOWER + {4'd0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/mem_hex_dumper.sv
// Reads an inclusive address range from memory and streams it as hex text.
// Each byte becomes two lowercase hex digits followed by a space or a newline (at end of line / end of range).
// Ports: clk, reset (async, active-high), bus (slave modport). Five cycles per byte at best; the
// character stream holds data stable while char_ready is low.
module mem_hex_dumper
    import mem_hex_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_REG_WIDTH,
    parameter int BYTES_PER_LINE = 8
) (
    input  logic             clk,
    input  logic             reset,
    mem_hex_dumper_if.slave  bus
);

    localparam int            LW        = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam logic [LW-1:0] LINE_LAST = LW'(BYTES_PER_LINE - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic [LW-1:0]         line_q, line_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;

    logic [3:0]            nibble;
    logic [7:0]            nibble_ascii;
    logic                  at_end;
    logic                  newline;

    assign at_end  = (addr_q == end_q);
    assign newline = at_end || (line_q == LINE_LAST);

    // One converter shared by the HI and LO digits.
    assign nibble = (state_q == ST_HI) ? byte_q[7:4] : byte_q[3:0];

    nibble_to_ascii u_nibble (
        .nibble_i (nibble),
        .ascii_o  (nibble_ascii)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            end_q  <= '0;
            line_q <= '0;
            byte_q <= '0;
        end else begin
            addr_q <= addr_d;
            end_q  <= end_d;
            line_q <= line_d;
            byte_q <= byte_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        line_d  = line_q;
        byte_d  = byte_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.start_addr;
                    end_d   = bus.end_addr;
                    line_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ:    state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                byte_d  = bus.mem_dout;
                state_d = ST_HI;
            end
            // char_valid is high in HI/LO/SEP, so char_ready alone marks the transfer.
            ST_HI: if (bus.char_ready) state_d = ST_LO;
            ST_LO: if (bus.char_ready) state_d = ST_SEP;
            ST_SEP: begin
                if (bus.char_ready) begin
                    line_d = newline ? '0 : line_q + 1'b1;
                    if (at_end) begin
                        state_d = ST_DONE;
                    end else begin
                        // Wraps naturally through the top of the address space.
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state only, so reset clears them immediately.
    always_comb begin
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.mem_re     = 1'b0;
        bus.mem_addr   = '0;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        unique case (state_q)
            ST_READ: begin
                bus.busy     = 1'b1;
                bus.mem_re   = 1'b1;
                bus.mem_addr = addr_q;
            end
            ST_CAPTURE: bus.busy = 1'b1;
            ST_HI, ST_LO: begin
                bus.busy       = 1'b1;
                bus.char_valid = 1'b1;
                bus.char_data  = nibble_ascii;
            end
            ST_SEP: begin
                bus.busy       = 1'b1;
                bus.char_valid = 1'b1;
                bus.char_data  = newline ? ASCII_NL : ASCII_SPACE;
            end
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_hex_dumper.sv
// Self-checking bench for mem_hex_dumper: a behavioural model predicts every character and
// memory address from the dump range, a compare process checks them each cycle, and literal
// strings pin the model for the directed cases.
module tb_mem_hex_dumper;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int BPL  = 8;
    localparam int SEED = 32'h5eed;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_hex_dumper_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

    mem_hex_dumper #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BYTES_PER_LINE (BPL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // Synchronous-read memory: data appears the cycle after mem_re.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ifc.mem_re) ifc.mem_dout <= mem[ifc.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [15:0] exp_addr_q[$];
    logic [15:0] got_addr_q[$];
    int          done_cnt;
    bit          stall_prev;
    logic [7:0]  prev_data;
    string       hx = "0123456789abcdef";

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic string esc(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "\\n"};
            else r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    function automatic string got_str();
        string r = "";
        foreach (got_q[i]) r = $sformatf("%s%c", r, got_q[i]);
        return r;
    endfunction

    task automatic chk_str(input string name, input string exp);
        string g;
        g = got_str();
        checks++;
        if (g != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, esc(g), esc(exp));
        end
    endtask

    // Model: byte i of the range lives at start+i (mod 2^16); it prints as two hex digits, then
    // a newline if it is the last of a line of BPL or the last of the range, else a space.
    task automatic model_load(input logic [15:0] sa, input logic [15:0] ea);
        logic [15:0] span;
        logic [15:0] a;
        logic [7:0]  b;
        int          n;
        span = ea - sa;
        n    = int'(span) + 1;
        for (int i = 0; i < n; i++) begin
            a = sa + 16'(i);
            b = mem[a];
            exp_addr_q.push_back(a);
            exp_q.push_back(hx[b[7:4]]);
            exp_q.push_back(hx[b[3:0]]);
            exp_q.push_back(((i % BPL) == BPL - 1 || i == n - 1) ? 8'h0A : 8'h20);
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            stall_prev = 1'b0;
        end else begin
            if (ifc.char_valid && stall_prev)
                chk("stall_stable", 32'(ifc.char_data), 32'(prev_data));
            if (ifc.char_valid)
                chk("busy_with_char", 32'(ifc.busy), 32'd1);
            if (ifc.char_valid && ifc.char_ready) begin
                got_q.push_back(ifc.char_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_char: got 0x%0h expected no character", ifc.char_data);
                end else begin
                    chk("char", 32'(ifc.char_data), 32'(exp_q.pop_front()));
                end
            end
            if (ifc.mem_re) begin
                got_addr_q.push_back(ifc.mem_addr);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_read: got addr 0x%0h expected no read", ifc.mem_addr);
                end else begin
                    chk("mem_addr", 32'(ifc.mem_addr), 32'(exp_addr_q.pop_front()));
                end
            end
            if (ifc.done) done_cnt++;
            stall_prev = ifc.char_valid && !ifc.char_ready;
            prev_data  = ifc.char_data;
        end
    end

    task automatic run_dump(input logic [15:0] sa, input logic [15:0] ea,
                            input bit rand_rdy, input int inject_cyc);
        int cyc;
        model_load(sa, ea);
        got_q.delete();
        got_addr_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        ifc.start      = 1'b1;
        ifc.start_addr = sa;
        ifc.end_addr   = ea;
        ifc.char_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            ifc.start = (cyc == inject_cyc);
            if (cyc == inject_cyc) begin
                ifc.start_addr = 16'h0000;
                ifc.end_addr   = 16'h0010;
            end
            ifc.char_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk); #1;
        end
        chk("dump_completes", 32'(done_cnt != 0), 32'd1);
        chk("busy_at_done", 32'(ifc.busy), 32'd0);
        @(posedge clk); #1;
        ifc.start      = 1'b0;
        ifc.char_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("chars_drained", 32'(exp_q.size()), 32'd0);
        chk("reads_drained", 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        void'($urandom(SEED));
        reset          = 1'b1;
        ifc.start      = 1'b0;
        ifc.start_addr = '0;
        ifc.end_addr   = '0;
        ifc.char_ready = 1'b1;
        done_cnt       = 0;
        stall_prev     = 1'b0;
        prev_data      = '0;
        mem[16'h0200] = 8'hA9;
        mem[16'h0201] = 8'h05;
        for (int i = 0; i < 9; i++) mem[16'h0300 + 16'(i)] = 8'(i);
        mem[16'hFFFF] = 8'h12;
        mem[16'h0000] = 8'h34;

        // Reset state
        @(negedge clk); #1;
        chk("rst_busy",       32'(ifc.busy),       32'd0);
        chk("rst_done",       32'(ifc.done),       32'd0);
        chk("rst_mem_re",     32'(ifc.mem_re),     32'd0);
        chk("rst_mem_addr",   32'(ifc.mem_addr),   32'd0);
        chk("rst_char_valid", 32'(ifc.char_valid), 32'd0);
        chk("rst_char_data",  32'(ifc.char_data),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Two bytes, sink always ready
        run_dump(16'h0200, 16'h0201, 1'b0, -1);
        chk_str("basic_text", "a9 05\n");
        chk("basic_first_char", 32'(got_q[0]), 32'h61);

        // Nine bytes across a line break, with a stray start mid-dump
        run_dump(16'h0300, 16'h0308, 1'b0, 10);
        chk_str("two_lines_text", "00 01 02 03 04 05 06 07\n08\n");
        chk("two_lines_count", 32'(got_q.size()), 32'd27);
        chk("two_lines_reads", 32'(got_addr_q.size()), 32'd9);

        // Same as the basic case with a stalling sink
        run_dump(16'h0200, 16'h0201, 1'b1, -1);
        chk_str("stall_text", "a9 05\n");

        // Range wrapping through the top of memory
        run_dump(16'hFFFF, 16'h0000, 1'b0, -1);
        chk_str("wrap_text", "12 34\n");
        chk("wrap_addr0", 32'(got_addr_q[0]), 32'h0000FFFF);
        chk("wrap_addr1", 32'(got_addr_q[1]), 32'h00000000);

        // Abort with reset during the low digit of the second byte
        model_load(16'h0200, 16'h0201);
        got_q.delete();
        got_addr_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        ifc.start      = 1'b1;
        ifc.start_addr = 16'h0200;
        ifc.end_addr   = 16'h0201;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        cyc = 0;
        while (got_q.size() < 4 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("abort_reached_lo", 32'(got_q.size()), 32'd4);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("abort_busy",       32'(ifc.busy),       32'd0);
        chk("abort_done",       32'(ifc.done),       32'd0);
        chk("abort_mem_re",     32'(ifc.mem_re),     32'd0);
        chk("abort_mem_addr",   32'(ifc.mem_addr),   32'd0);
        chk("abort_char_valid", 32'(ifc.char_valid), 32'd0);
        chk("abort_char_data",  32'(ifc.char_data),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        repeat (4) @(negedge clk);
        #1;
        chk("abort_no_partial", 32'(got_q.size()), 32'd4);
        chk("abort_no_done",    32'(done_cnt),     32'd0);
        run_dump(16'h0200, 16'h0200, 1'b0, -1);
        chk_str("restart_text", "a9\n");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_hex_dumper.md
MEM_HEX_DUMPER -- requirements
Module: mem_hex_dumper

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (16), memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default `REG_WIDTH (8), memory word width.
REQ-003 SHALL have parameter BYTES_PER_LINE, default 8, bytes emitted per text line.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a dump.
REQ-007 SHALL have port start_addr  in  ADDR_WIDTH  first address, sampled with start.
REQ-008 SHALL have port end_addr  in  ADDR_WIDTH  last address (inclusive), sampled with start.
REQ-009 SHALL have port busy  out  1  high from the cycle after accepted start until done.
REQ-010 SHALL have port done  out  1  one-cycle pulse at dump completion.
REQ-011 SHALL have port mem_re  out  1  memory read strobe.
REQ-012 SHALL have port mem_addr  out  ADDR_WIDTH  memory read address.
REQ-013 SHALL have port mem_dout  in  DATA_WIDTH  read data, valid the cycle after mem_re.
REQ-014 SHALL have port char_valid  out  1  ASCII character available.
REQ-015 SHALL have port char_data  out  8  ASCII character.
REQ-016 SHALL have port char_ready  in  1  sink accepts character.

Function
REQ-017 SHALL implement FSM states IDLE, READ, CAPTURE, HI, LO, SEP, DONE.
REQ-018 IDLE: start=1 SHALL latch start_addr/end_addr, clear the line counter, go to READ; start while not IDLE SHALL be ignored.
REQ-019 READ: mem_re=1 and mem_addr=current address for exactly one cycle, then go to CAPTURE.
REQ-020 CAPTURE: SHALL register mem_dout into a byte register, then go to HI.
REQ-021 HI/LO/SEP SHALL each drive char_valid=1 and leave the state only on the cycle with char_valid && char_ready.
REQ-022 char_data SHALL remain stable while char_valid=1 and char_ready=0.
REQ-023 HI SHALL emit the upper nibble and LO the lower nibble, as lowercase ASCII hex: 0-9 -> 0x30-0x39, a-f -> 0x61-0x66.
REQ-024 SEP SHALL emit 0x0A when the line counter equals BYTES_PER_LINE-1 or the current address equals end_addr; otherwise it SHALL emit 0x20.
REQ-025 After the SEP transfer, the line counter SHALL reset to 0 on a newline and increment otherwise.
REQ-026 After the SEP transfer, the block SHALL go to DONE if the current address equals end_addr; otherwise it SHALL increment the address modulo 2^ADDR_WIDTH and go to READ.
REQ-027 A dump SHALL cover (end_addr - start_addr) mod 2^ADDR_WIDTH + 1 bytes, so end_addr < start_addr wraps through the maximum address.
REQ-028 DONE: done=1 for one cycle, busy=0, then return to IDLE.
REQ-029 Minimum throughput with char_ready held at 1 SHALL be 5 cycles per byte.

Reset
REQ-030 reset=1 SHALL immediately force IDLE and drive busy, done, mem_re, char_valid to 0, and mem_addr, char_data to 0.
REQ-031 Reset asserted mid-dump SHALL abort the dump; no partial character SHALL be emitted after release.

Structure
REQ-032 The shared package (PKG/pkg.v) SHALL hold the state enum typedef and the ASCII constants for space, newline, '0' and 'a'.
REQ-033 A combinational sub-module nibble_to_ascii (4-bit in, 8-bit out) SHALL be instantiated once, selected by HI/LO.

Verification
REQ-034 mem[0x0200]=0xA9, mem[0x0201]=0x05, start 0x0200..0x0201, char_ready=1 -> chars 0x61,0x39,0x20,0x30,0x35,0x0A, then one done pulse.
REQ-035 9 bytes 0x00..0x08 at 0x0300, BYTES_PER_LINE=8 -> "00 01 02 03 04 05 06 07\n08\n".
REQ-036 Repeat REQ-034 with char_ready randomly toggled (seed `SEED) -> identical character sequence; char_data stable under stall.
REQ-037 mem[0xFFFF]=0x12, mem[0x0000]=0x34, start 0xFFFF..0x0000 -> "12 34\n"; mem_addr sequence 0xFFFF then 0x0000.
REQ-038 reset pulsed during LO of the second byte -> next cycle all outputs 0; a new start 0x0200..0x0200 afterwards -> "a9\n" and done.
REQ-039 A second start pulse during a dump -> ignored; output and byte count unchanged.
